// File: rtl/imem_dmem_bus_arbiter.sv
// imem_dmem_bus_arbiter: shares one pipelined Avalon-MM agent between the instruction-fetch
// host (read-only) and the data host (read/write).
// Arbitration is round-robin. The grant is held while the agent stalls. Read responses are
// steered back to the issuing host through an in-order ID FIFO.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   i_*                 instruction host (address, read, waitrequest, readdatavalid, readdata)
//   d_*                 data host (address, read, write, byteenable, writedata, waitrequest,
//                       readdatavalid, readdata)
//   m_*                 agent port (address, read, write, byteenable, writedata, waitrequest,
//                       readdatavalid, readdata)
//   err_unexpected      sticky flag: a response arrived with no read outstanding
module imem_dmem_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_PENDING = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_read,
    output logic                i_waitrequest,
    output logic                i_readdatavalid,
    output logic [DATA_W-1:0]   i_readdata,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W/8-1:0] d_byteenable,
    input  logic [DATA_W-1:0]   d_writedata,
    output logic                d_waitrequest,
    output logic                d_readdatavalid,
    output logic [DATA_W-1:0]   d_readdata,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic [DATA_W-1:0]   m_writedata,
    input  logic                m_waitrequest,
    input  logic                m_readdatavalid,
    input  logic [DATA_W-1:0]   m_readdata,
    output logic                err_unexpected
);
    localparam int PW = $clog2(MAX_PENDING);
    localparam int CW = PW + 1;

    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;
    typedef enum logic {FREE, LOCKED} lock_t;

    lock_t                  lock_q, lock_d;
    owner_t                 lock_owner_q, last_q, owner;
    logic                   gnt, full, empty, elig_i, elig_d, push, pop;
    logic [MAX_PENDING-1:0] ids;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;

    assign i_readdata = m_readdata;
    assign d_readdata = m_readdata;

    always_comb begin
        full   = count == CW'(MAX_PENDING);
        empty  = count == '0;
        // A read can only be taken when its ID has somewhere to go; writes need no slot.
        elig_i = i_read && !full;
        elig_d = d_write || (d_read && !full);
        gnt    = 1'b0;
        owner  = OWN_I;
        if (lock_q == LOCKED) begin
            gnt   = 1'b1;
            owner = lock_owner_q;
        end else if (elig_i && elig_d) begin
            gnt   = 1'b1;
            owner = (last_q == OWN_I) ? OWN_D : OWN_I;
        end else if (elig_d) begin
            gnt   = 1'b1;
            owner = OWN_D;
        end else if (elig_i) begin
            gnt   = 1'b1;
            owner = OWN_I;
        end
        m_read        = gnt && ((owner == OWN_D) ? d_read : i_read);
        m_write       = gnt && (owner == OWN_D) && d_write;
        m_address     = !gnt ? '0 : (owner == OWN_D) ? d_address : i_address;
        m_byteenable  = !gnt ? '0 : (owner == OWN_D) ? d_byteenable : '1;
        m_writedata   = (gnt && owner == OWN_D) ? d_writedata : '0;
        i_waitrequest = (gnt && owner == OWN_I) ? m_waitrequest : 1'b1;
        d_waitrequest = (gnt && owner == OWN_D) ? m_waitrequest : 1'b1;
        // A stalled command keeps the bus; anything else releases it.
        lock_d        = ((m_read || m_write) && m_waitrequest) ? LOCKED : FREE;
        push          = m_read && !m_waitrequest;
        pop           = m_readdatavalid && !empty;
        i_readdatavalid = pop && (ids[rd_ptr] == OWN_I);
        d_readdatavalid = pop && (ids[rd_ptr] == OWN_D);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q         <= FREE;
            lock_owner_q   <= OWN_I;
            last_q         <= OWN_I;
            ids            <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            err_unexpected <= 1'b0;
        end else begin
            lock_q <= lock_d;
            if (lock_d == LOCKED) lock_owner_q <= owner;
            if ((m_read || m_write) && !m_waitrequest) last_q <= owner;
            if (push) begin
                ids[wr_ptr] <= owner;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (m_readdatavalid && empty) err_unexpected <= 1'b1;
        end
    end
endmodule

// File: tb/tb_imem_dmem_bus_arbiter.sv
// tb_imem_dmem_bus_arbiter: vector table plus hand sequences with a response-routing scoreboard.
module tb_imem_dmem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] i_address, d_address, d_writedata, m_address, m_writedata, m_readdata;
    logic [31:0] i_readdata, d_readdata;
    logic [3:0]  d_byteenable, m_byteenable;
    logic        i_read, i_waitrequest, i_readdatavalid;
    logic        d_read, d_write, d_waitrequest, d_readdatavalid;
    logic        m_read, m_write, m_waitrequest, m_readdatavalid, err_unexpected;

    always #5 clk = ~clk;

    imem_dmem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest),
        .i_readdatavalid(i_readdatavalid), .i_readdata(i_readdata),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_byteenable(d_byteenable), .d_writedata(d_writedata),
        .d_waitrequest(d_waitrequest), .d_readdatavalid(d_readdatavalid), .d_readdata(d_readdata),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_byteenable(m_byteenable), .m_writedata(m_writedata),
        .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid),
        .m_readdata(m_readdata), .err_unexpected(err_unexpected)
    );

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr, dw;
        logic [31:0] da;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        mw, rdv;
        logic        er, ew;
        logic [31:0] ea;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic        eiw, edw;
        int          push;
        logic        ck;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   sb[$];
    vec_t tbl[$];
    vec_t idle, resp;

    function automatic vec_t v(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                               input logic [31:0] da, input logic [3:0] be, input logic [31:0] wd,
                               input logic mw, input logic rdv, input logic er, input logic ew,
                               input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ewd,
                               input logic eiw, input logic edw, input int push, input logic ck);
        vec_t t;
        t.ir = ir;  t.ia = ia;   t.dr = dr;   t.dw = dw;   t.da = da;   t.be = be;
        t.wd = wd;  t.mw = mw;   t.rdv = rdv; t.er = er;   t.ew = ew;   t.ea = ea;
        t.ebe = ebe; t.ewd = ewd; t.eiw = eiw; t.edw = edw; t.push = push; t.ck = ck;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t t);
        i_read = t.ir; i_address = t.ia; d_read = t.dr; d_write = t.dw; d_address = t.da;
        d_byteenable = t.be; d_writedata = t.wd; m_waitrequest = t.mw; m_readdatavalid = t.rdv;
    endtask

    // One cycle: drive, compare combinational outputs, then settle the scoreboard
    // (pop the oldest expected ID before pushing a newly accepted read).
    task automatic apply(input vec_t t);
        logic [31:0] rd;
        int          id;
        @(negedge clk);
        drive(t);
        rd = $urandom;
        m_readdata = rd;
        #1;
        if (t.ck) begin
            chk("m_read", 32'(m_read), 32'(t.er));
            chk("m_write", 32'(m_write), 32'(t.ew));
            chk("m_address", m_address, t.ea);
            chk("m_byteenable", 32'(m_byteenable), 32'(t.ebe));
            chk("m_writedata", m_writedata, t.ewd);
            chk("i_waitrequest", 32'(i_waitrequest), 32'(t.eiw));
            chk("d_waitrequest", 32'(d_waitrequest), 32'(t.edw));
        end
        if (t.rdv && sb.size() > 0) begin
            id = sb.pop_front();
            chk("i_readdatavalid", 32'(i_readdatavalid), 32'(id == 0));
            chk("d_readdatavalid", 32'(d_readdatavalid), 32'(id == 1));
            chk(id == 0 ? "i_readdata" : "d_readdata", id == 0 ? i_readdata : d_readdata, rd);
        end else begin
            chk("i_readdatavalid_idle", 32'(i_readdatavalid), 32'd0);
            chk("d_readdatavalid_idle", 32'(d_readdatavalid), 32'd0);
        end
        if (t.push != 0) sb.push_back(t.push - 1);
    endtask

    initial begin
        idle = v(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1, 0, 1);
        resp = v(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 1);
        // tie from reset: DATA first, then INSTR; responses D then I
        tbl.push_back(v(1, 'h10, 1, 0, 'h20, 4'ha, 0, 0, 0,  1, 0, 'h20, 4'ha, 0, 1, 0, 2, 1));
        tbl.push_back(v(1, 'h10, 0, 0, 0, 0, 0, 0, 0,  1, 0, 'h10, 4'hf, 0, 0, 1, 1, 1));
        tbl.push_back(resp);
        tbl.push_back(resp);
        // lone instruction read, routed back to INSTR
        tbl.push_back(v(1, 'h100, 0, 0, 0, 0, 0, 0, 0,  1, 0, 'h100, 4'hf, 0, 0, 1, 1, 1));
        tbl.push_back(resp);
        // write accepted at once leaves last_grant=DATA
        tbl.push_back(v(0, 0, 0, 1, 'h44, 4'hf, 'h11112222, 0, 0,  0, 1, 'h44, 4'hf, 'h11112222, 1, 0, 0, 1));
        // stalled write: grant stays DATA although INSTR would win round-robin
        tbl.push_back(v(0, 0, 0, 1, 'h40, 4'h3, 'hdeadbeef, 1, 0,  0, 1, 'h40, 4'h3, 'hdeadbeef, 1, 1, 0, 1));
        tbl.push_back(v(1, 'h80, 0, 1, 'h40, 4'h3, 'hdeadbeef, 1, 0,  0, 1, 'h40, 4'h3, 'hdeadbeef, 1, 1, 0, 1));
        tbl.push_back(v(1, 'h80, 0, 1, 'h40, 4'h3, 'hdeadbeef, 1, 0,  0, 1, 'h40, 4'h3, 'hdeadbeef, 1, 1, 0, 1));
        tbl.push_back(v(1, 'h80, 0, 1, 'h40, 4'h3, 'hdeadbeef, 0, 0,  0, 1, 'h40, 4'h3, 'hdeadbeef, 1, 0, 0, 1));
        tbl.push_back(v(1, 'h80, 0, 0, 0, 0, 0, 0, 0,  1, 0, 'h80, 4'hf, 0, 0, 1, 1, 1));
        tbl.push_back(resp);

        drive(idle);
        m_readdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_m_read", 32'(m_read), 32'd0);
        chk("rst_m_write", 32'(m_write), 32'd0);
        chk("rst_m_address", m_address, 32'd0);
        chk("rst_m_byteenable", 32'(m_byteenable), 32'd0);
        chk("rst_m_writedata", m_writedata, 32'd0);
        chk("rst_i_waitrequest", 32'(i_waitrequest), 32'd1);
        chk("rst_d_waitrequest", 32'(d_waitrequest), 32'd1);
        chk("rst_err", 32'(err_unexpected), 32'd0);
        rst = 1'b1;

        apply(idle);
        for (int k = 0; k < tbl.size(); k++) apply(tbl[k]);

        // fill the ID FIFO with four instruction reads
        for (int k = 0; k < 4; k++)
            apply(v(1, 32'('h200 + 4 * k), 0, 0, 0, 0, 0, 0, 0,
                    1, 0, 32'('h200 + 4 * k), 4'hf, 0, 0, 1, 1, 1));
        // full: fifth read stalls, write still goes through
        apply(v(1, 'h210, 0, 1, 'h50, 4'hf, 'h55, 0, 0,  0, 1, 'h50, 4'hf, 'h55, 1, 0, 0, 1));
        // a response frees a slot, the held read is taken on the following cycle
        apply(v(1, 'h210, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 0));
        apply(v(1, 'h210, 0, 0, 0, 0, 0, 0, 0,  1, 0, 'h210, 4'hf, 0, 0, 1, 1, 1));
        repeat (4) apply(resp);

        // interleaved I,D,D,I with latency 3; fourth issue coincides with first response
        apply(v(1, 'h300, 0, 0, 0, 0, 0, 0, 0,  1, 0, 'h300, 4'hf, 0, 0, 1, 1, 1));
        apply(v(0, 0, 1, 0, 'h304, 4'hf, 0, 0, 0,  1, 0, 'h304, 4'hf, 0, 1, 0, 2, 1));
        apply(v(0, 0, 1, 0, 'h308, 4'hf, 0, 0, 0,  1, 0, 'h308, 4'hf, 0, 1, 0, 2, 1));
        apply(v(1, 'h30c, 0, 0, 0, 0, 0, 0, 1,  1, 0, 'h30c, 4'hf, 0, 0, 1, 1, 1));
        repeat (3) apply(resp);
        chk("err_before_extra_rdv", 32'(err_unexpected), 32'd0);

        // FIFO must be empty now: an extra response is dropped and flagged
        apply(resp);
        apply(idle);
        chk("err_after_unexpected", 32'(err_unexpected), 32'd1);

        // reset while a read is outstanding
        apply(v(1, 'h400, 0, 0, 0, 0, 0, 0, 0,  1, 0, 'h400, 4'hf, 0, 0, 1, 1, 1));
        @(negedge clk);
        drive(idle);
        rst = 1'b0;
        #1;
        chk("midrst_m_read", 32'(m_read), 32'd0);
        chk("midrst_m_address", m_address, 32'd0);
        chk("midrst_i_waitrequest", 32'(i_waitrequest), 32'd1);
        chk("midrst_d_waitrequest", 32'(d_waitrequest), 32'd1);
        chk("midrst_err", 32'(err_unexpected), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        apply(resp);
        apply(idle);
        chk("err_after_reset_rdv", 32'(err_unexpected), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
